// File: rtl/proc_imul_pkg.sv
// -----------------------------------------------------------------------------
// proc_imul_pkg
// Shared types and constants for the iterative integer multiply unit that
// feeds the MUL input of the X-stage result select mux.
//   P_NBITS_DEFAULT : default operand/result width
//   imul_state_e    : control FSM state encoding (IDLE, CALC, DONE)
// -----------------------------------------------------------------------------
package proc_imul_pkg;

  localparam int P_NBITS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } imul_state_e;

endpackage

// File: rtl/proc_imul_seq_dpath.sv
// -----------------------------------------------------------------------------
// proc_imul_seq_dpath
// Shift-add datapath for the iterative multiplier. Holds the shifted
// multiplicand, the shifted multiplier, the accumulator and the step counter.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_load           : capture operands, clear accumulator and counter
//   i_step           : perform one shift-add step
//   i_add            : add the multiplicand into the accumulator this step
//   i_a, i_b         : multiplicand / multiplier operands
//   o_b_lsb          : current multiplier LSB (selects the add)
//   o_b_next_zero    : multiplier is zero after this step's shift
//   o_count_last     : this step is the final one of a full-width pass
//   o_acc            : accumulator (low p_nbits of the product when done)
// -----------------------------------------------------------------------------
module proc_imul_seq_dpath
  import proc_imul_pkg::*;
#(
  parameter int p_nbits = P_NBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_add,
  input  logic [p_nbits-1:0] i_a,
  input  logic [p_nbits-1:0] i_b,
  output logic               o_b_lsb,
  output logic               o_b_next_zero,
  output logic               o_count_last,
  output logic [p_nbits-1:0] o_acc
);

  localparam int c_cw = $clog2(p_nbits);
  localparam logic [c_cw-1:0] c_count_last = c_cw'(p_nbits - 1);
  localparam logic [c_cw-1:0] c_count_one  = c_cw'(1);

  logic [p_nbits-1:0] r_a;
  logic [p_nbits-1:0] r_b;
  logic [p_nbits-1:0] r_acc;
  logic [c_cw-1:0]    r_count;
  logic [p_nbits-1:0] w_b_shift;
  logic [p_nbits-1:0] w_acc_sum;

  assign w_b_shift     = r_b >> 1'b1;
  // Wraps mod 2^p_nbits, which is exactly the low half of the product.
  assign w_acc_sum     = r_acc + r_a;
  assign o_b_lsb       = r_b[0];
  assign o_b_next_zero = (w_b_shift == '0);
  assign o_count_last  = (r_count == c_count_last);
  assign o_acc         = r_acc;

  // Operand capture and one shift-add step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_step) begin
      if (i_add) begin
        r_acc <= w_acc_sum;
      end
      r_a     <= r_a << 1'b1;
      r_b     <= w_b_shift;
      r_count <= r_count + c_count_one;
    end
  end

endmodule

// File: rtl/proc_imul_seq_unit.sv
// -----------------------------------------------------------------------------
// proc_imul_seq_unit
// Iterative integer multiplier for the X stage: accepts operands over a
// val/rdy request interface, performs one shift-add step per cycle, and
// returns the low p_nbits of a*b over a val/rdy response interface. A kill
// squashes an in-flight or pending operation.
// Build option: define PROC_IMUL_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero (latency follows the multiplier MSB).
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   req_val/req_rdy       : request handshake (req_rdy=0 while kill=1)
//   req_a, req_b          : multiplicand / multiplier
//   resp_val/resp_rdy     : response handshake
//   resp_result           : low p_nbits of the product
//   kill                  : squash current operation / block accept
//   busy                  : operation in CALC or DONE
// -----------------------------------------------------------------------------
module proc_imul_seq_unit
  import proc_imul_pkg::*;
#(
  parameter int p_nbits = P_NBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result,
  input  logic               kill,
  output logic               busy
);

`ifdef PROC_IMUL_EARLY_TERM_EN
  localparam bit c_early_term = 1'b1;
`else
  localparam bit c_early_term = 1'b0;
`endif

  imul_state_e        r_state;
  imul_state_e        w_state_next;
  logic               w_load;
  logic               w_step;
  logic               w_add;
  logic               w_calc_exit;
  logic               w_b_lsb;
  logic               w_b_next_zero;
  logic               w_count_last;
  logic [p_nbits-1:0] w_acc;

  assign w_load      = (r_state == IDLE) && req_val && !kill;
  assign w_step      = (r_state == CALC);
  assign w_add       = w_step && w_b_lsb;
  // Full-width pass ends on the last count; early exit when nothing is left.
  assign w_calc_exit = w_count_last || (c_early_term && w_b_next_zero);

  proc_imul_seq_dpath #(
    .p_nbits(p_nbits)
  ) u_dpath (
    .clk          (clk),
    .rst_n        (reset),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_add        (w_add),
    .i_a          (req_a),
    .i_b          (req_b),
    .o_b_lsb      (w_b_lsb),
    .o_b_next_zero(w_b_next_zero),
    .o_count_last (w_count_last),
    .o_acc        (w_acc)
  );

  // Next-state logic; kill wins over completion and over resp_rdy.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_next = CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      CALC: begin
        if (kill) begin
          w_state_next = IDLE;
        end else if (w_calc_exit) begin
          w_state_next = DONE;
        end else begin
          w_state_next = CALC;
        end
      end
      DONE: begin
        if (kill || resp_rdy) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs decode state only; kill gates req_rdy so a squashed cycle never accepts.
  assign req_rdy     = (r_state == IDLE) && !kill;
  assign resp_val    = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign resp_result = w_acc;

endmodule

// File: tb/tb_proc_imul_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_proc_imul_seq_unit
// Directed bench for proc_imul_seq_unit. Requests push their hand-computed
// product and expected response cycle into a scoreboard; a monitor pops and
// compares whenever the unit presents a response.
// -----------------------------------------------------------------------------
module tb_proc_imul_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_result;
  logic        kill;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_val = 1'b0;

`ifdef PROC_IMUL_EARLY_TERM_EN
  localparam int KILL_CYC = 3;
`else
  localparam int KILL_CYC = 10;
`endif

  proc_imul_seq_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_result(resp_result),
    .kill       (kill),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Number of CALC cycles the unit should spend on multiplier b.
  function automatic int calc_cycles(input logic [31:0] b);
`ifdef PROC_IMUL_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 1; i < 32; i++) begin
      if (b[i]) n = i + 1;
    end
    return n;
`else
    return 32;
`endif
  endfunction

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (resp_val) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stale_resp: got resp_val=1 result 0x%08h expected no response (cycle %0d)",
                 resp_result, cyc);
      end else begin
        if (!prev_val) check("resp_cycle", cyc, sb[0].cyc);
        check("resp_result", resp_result, sb[0].res);
        if (resp_rdy) void'(sb.pop_front());
      end
    end
    prev_val = resp_val;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input bit push, output int c0);
    @(negedge clk);
    req_a   = a;
    req_b   = b;
    req_val = 1'b1;
    #1;
    check("req_rdy_idle", req_rdy, 32'd1);
    c0 = cyc;
    if (push) sb.push_back('{exp, c0 + 1 + calc_cycles(b)});
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    check("wait_idle_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    bit  seen;
    reset    = 1'b0;
    req_val  = 1'b0;
    req_a    = 32'd0;
    req_b    = 32'd0;
    resp_rdy = 1'b1;
    kill     = 1'b0;

    // Reset state
    #12;
    check("rst_req_rdy", req_rdy, 32'd1);
    check("rst_resp_val", resp_val, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_result", resp_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3*5, ready again one cycle after the response
    issue(32'd3, 32'd5, 32'd15, 1'b1, c0);
    repeat (calc_cycles(32'd5) + 2) @(negedge clk);
    #1;
    check("basic_req_rdy_after", req_rdy, 32'd1);
    check("basic_busy_after", busy, 32'd0);
    wait_idle();

    // Overflow / wrap of the low half
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, c0);
    wait_idle();
    issue(32'h8000_0000, 32'd2, 32'h0000_0000, 1'b1, c0);
    wait_idle();

    // Small / large multipliers (early-exit boundaries when enabled)
    issue(32'h0000_1234, 32'd1, 32'h0000_1234, 1'b1, c0);
    wait_idle();
    issue(32'd5, 32'd0, 32'd0, 1'b1, c0);
    wait_idle();
    issue(32'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, c0);
    wait_idle();

    // Backpressure: 7*6 held for four cycles
    resp_rdy = 1'b0;
    issue(32'd7, 32'd6, 32'd42, 1'b1, c0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (resp_val) seen = 1'b1;
    end
    check("bp_resp_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("bp_resp_val_hold", resp_val, 32'd1);
      check("bp_req_rdy_low", req_rdy, 32'd0);
      check("bp_busy", busy, 32'd1);
      @(negedge clk);
      if (i == 3) resp_rdy = 1'b1;
      #1;
    end
    @(negedge clk);
    #1;
    check("bp_idle_resp_val", resp_val, 32'd0);
    check("bp_idle_req_rdy", req_rdy, 32'd1);
    wait_idle();

    // Kill during CALC: no response may ever appear
    issue(32'd9, 32'd9, 32'd81, 1'b0, c0);
    repeat (KILL_CYC) @(negedge clk);
    kill = 1'b1;
    #1;
    check("kill_busy_calc", busy, 32'd1);
    check("kill_req_rdy", req_rdy, 32'd0);
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    #1;
    check("kill_idle_busy", busy, 32'd0);
    check("kill_idle_req_rdy", req_rdy, 32'd1);
    repeat (40) @(negedge clk);

    // Kill in IDLE blocks the accept
    @(negedge clk);
    req_a   = 32'd4;
    req_b   = 32'd4;
    req_val = 1'b1;
    kill    = 1'b1;
    #1;
    check("kill_blocks_rdy", req_rdy, 32'd0);
    @(posedge clk);
    #1;
    req_val = 1'b0;
    kill    = 1'b0;
    @(negedge clk);
    #1;
    check("kill_no_accept", busy, 32'd0);
    issue(32'd4, 32'd4, 32'd16, 1'b1, c0);
    wait_idle();

    // Asynchronous reset mid-CALC
    issue(32'd11, 32'hFFFF_FFFF, 32'd0, 1'b0, c0);
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_req_rdy", req_rdy, 32'd1);
    check("arst_resp_val", resp_val, 32'd0);
    check("arst_result", resp_result, 32'd0);
    check("arst_busy", busy, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("arst_stays_idle", busy, 32'd0);

    // Normal operation after reset
    issue(32'd3, 32'd5, 32'd15, 1'b1, c0);
    wait_idle();
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_imul_seq_unit.md
Name: proc_imul_seq_unit

Overview:
Iterative 32-bit integer multiply unit with its own control FSM. It fills the MUL input of the X-stage ex_result select mux in the 5-stage pipeline.
- X-stage control issues operands over a val/rdy request interface and consumes the product over a val/rdy response interface.
- The unit sequences one shift-add step per cycle.
- It supports squash, so a multiply on a mispredicted path can be cancelled.

Parameters:
p_nbits, 32, operand/result width; counter width is $clog2(p_nbits).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_val  input  1  operands valid.
req_rdy  output  1  unit can accept operands.
req_a  input  p_nbits  multiplicand (op1_X).
req_b  input  p_nbits  multiplier (op2_X).
resp_val  output  1  result valid.
resp_rdy  input  1  consumer takes result.
resp_result  output  p_nbits  low p_nbits of a*b.
kill  input  1  squash in-flight or pending operation.
busy  output  1  high in CALC or DONE.

Behaviour:
- States and outputs:
  - IDLE: req_rdy=1 (0 while kill=1), resp_val=0, busy=0.
  - CALC: req_rdy=0, resp_val=0, busy=1.
  - DONE: req_rdy=0, resp_val=1, busy=1.
- Reset (reset=0, async): state=IDLE, a_reg/b_reg/acc/count=0, resp_result=0. This applies mid-operation too; the in-flight op is lost and no response is issued.
- IDLE transitions:
  - Accept when req_val && req_rdy: a_reg<=req_a, b_reg<=req_b, acc<=0, count<=0, go to CALC.
  - If kill=1 in the same cycle, nothing is accepted.
- CALC, each cycle:
  - if b_reg[0], acc<=acc+a_reg (mod 2^p_nbits);
  - a_reg<=a_reg<<1; b_reg<=b_reg>>1; count<=count+1.
  - Exit to DONE after the step where count==p_nbits-1, i.e. exactly p_nbits CALC cycles.
- DONE: resp_result=acc, held stable while resp_rdy=0. On resp_rdy=1, go to IDLE. There is no same-cycle re-accept; req_rdy stays 0 in DONE.
- Latency: request accepted in cycle 0 gives resp_val=1 in cycle p_nbits+1 (33). Throughput is one op per 34 cycles when resp_rdy=1 immediately.
- Result is the low p_nbits bits of the product; signedness does not matter for the low half.
- kill:
  - In CALC or DONE: next state IDLE, resp_val=0 next cycle, result discarded. kill has priority over resp_rdy in DONE.
  - In IDLE: blocks accept only.
- Outputs are registered or state-decoded only; there is no combinational path from req_val/resp_rdy to req_rdy/resp_val.

Optional Feature:
PROC_IMUL_EARLY_TERM_EN
- Defined: CALC also exits to DONE after any step where the shifted b_reg (b_reg>>1) is 0, so latency tracks the multiplier's MSB position.
  - b=0 or b=1: 1 CALC cycle, resp_val in cycle 2.
  - b=5: 3 CALC cycles, resp_val in cycle 4.
- Undefined: fixed p_nbits CALC cycles, as above.
- Results are identical either way.

Decomposition:
- Package proc_imul_pkg: state enum typedef (IDLE, CALC, DONE, 2-bit) and the default width constant 32.
- Sub-module proc_imul_seq_dpath holds a_reg, b_reg, acc, count, the adder and the shifters. Its inputs are load/step controls from the FSM; its outputs are b_lsb, b_next_zero and count_last.
- The top level holds the FSM and the handshake logic.

Test Plan:
- Basic: a=3, b=5, resp_rdy=1, macro undefined -> resp_val in cycle 33 with resp_result=15; req_rdy=1 again in cycle 34.
- Overflow: a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_result=0x00000001. Also a=0x80000000, b=2 -> 0x00000000.
- Backpressure: a=7, b=6, resp_rdy=0 for 4 cycles after resp_val rises -> resp_val and 42 held stable; req_rdy=0 throughout; IDLE the cycle after resp_rdy=1.
- Kill: a=9, b=9, assert kill in CALC cycle 10 -> IDLE next cycle, no resp_val ever. A new request 4*4 then completes with 16.
- Reset: drop reset in CALC cycle 20 (async, mid-cycle) -> req_rdy=1, resp_val=0, resp_result=0 immediately. No stale response after release.
- Early term (macro defined): b=1, a=0x1234 -> resp_val cycle 2, 0x1234. b=0 -> cycle 2, result 0. b=0x80000000, a=1 -> cycle 33, 0x80000000.
